// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths, latency and helpers for the Sobel edge stage.
//   PIX_W  - grayscale pixel width
//   MAG_W  - gradient / magnitude width (holds +-1020 signed, 2040 unsigned)
//   LAT    - input-to-output latency in clocks
//   pix_t  - one pixel
//   grad_t - one signed gradient component
package sobel_pkg;

  localparam int PIX_W = 8;
  localparam int MAG_W = 11;
  localparam int LAT   = 4;

  typedef logic [PIX_W-1:0]        pix_t;
  typedef logic signed [MAG_W-1:0] grad_t;

  // Weighted column/row sum a + 2b + c; max 1020, so it always fits MAG_W.
  function automatic logic [MAG_W-1:0] tap_sum(input pix_t a, input pix_t b, input pix_t c);
    return MAG_W'(a) + (MAG_W'(b) << 1) + MAG_W'(c);
  endfunction

  // |g| as unsigned; -1024 never occurs because gradients stay within +-1020.
  function automatic logic [MAG_W-1:0] abs_grad(input grad_t g);
    return g[MAG_W-1] ? $unsigned(-g) : $unsigned(g);
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: two-line delay for the 3x3 window.
//   clk, rst_n - clock, async active-low reset (taps only)
//   din        - incoming pixel of row r
//   din_vld    - write enable for both line arrays
//   col        - column of the incoming pixel (read and write address)
//   tap0       - din registered (row r)
//   tap1       - line1[col] registered (row r-1)
//   tap2       - line2[col] registered (row r-2)
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  pix_t             din,
  input  logic             din_vld,
  input  logic [COL_W-1:0] col,
  output pix_t             tap0,
  output pix_t             tap1,
  output pix_t             tap2
);

  pix_t line1 [IMG_W];
  pix_t line2 [IMG_W];

  // Line storage is deliberately not reset; stale contents only ever reach
  // border positions, which the top level masks to 0.
  always_ff @(posedge clk) begin
    if (din_vld) begin
      line1[col] <= din;
      line2[col] <= line1[col];
    end
  end

  // Taps load every clock; the window only consumes them one clock after a
  // valid pixel, so off-cycle values are harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap0 <= '0;
      tap1 <= '0;
      tap2 <= '0;
    end else begin
      tap0 <= din;
      tap1 <= line1[col];
      tap2 <= line2[col];
    end
  end

endmodule

// File: rtl/sobel_edge.sv
// sobel_edge: 3x3 Sobel |Gx|+|Gy| edge detector on a framed 8-bit pixel stream.
// One 1-bit output per input pixel, fixed latency LAT clocks.
//   clk, rst_n        - clock, async active-low reset
//   din               - grayscale pixel
//   din_vld           - pixel valid (arbitrary gaps allowed)
//   din_sop/din_eop   - first/last pixel of frame, qualified by din_vld
//   thresh            - edge threshold, captured on each accepted sop
//   dout              - edge flag (0 on the 2-pixel top/left border)
//   dout_vld/sop/eop  - input sideband delayed LAT clocks
module sobel_edge
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  pix_t             din,
  input  logic             din_vld,
  input  logic             din_sop,
  input  logic             din_eop,
  input  logic [MAG_W-1:0] thresh,
  output logic             dout,
  output logic             dout_vld,
  output logic             dout_sop,
  output logic             dout_eop
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0] col_q, cur_col;
  logic [ROW_W-1:0] row_q, cur_row;
  logic             col_last, row_last, border_in;

  logic [MAG_W-1:0] thr_q;
  logic [LAT-1:0]   vld_sr, sop_sr, eop_sr;

  pix_t             tap0, tap1, tap2;
  logic             border_d1, border_d2, border_d3;
  pix_t             win [3][3];
  grad_t            gx_c, gy_c, gx_q, gy_q;
  logic [MAG_W-1:0] mag;

  // col_q/row_q hold the position of the next pixel; an accepted sop
  // overrides that so the sop pixel itself is (0,0).
  always_comb begin
    cur_col   = col_q;
    cur_row   = row_q;
    if (din_vld && din_sop) begin
      cur_col = '0;
      cur_row = '0;
    end
    col_last  = (cur_col == COL_W'(IMG_W - 1));
    row_last  = (cur_row == ROW_W'(IMG_H - 1));
    border_in = (cur_col < COL_W'(2)) || (cur_row < ROW_W'(2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (din_vld) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_q <= cur_col + COL_W'(1);
        row_q <= cur_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q <= '0;
    end else if (din_vld && din_sop) begin
      thr_q <= thresh;
    end
  end

  // Sideband runs through an ungated chain so output spacing mirrors input spacing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
      sop_sr <= '0;
      eop_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[LAT-2:0], din_vld};
      sop_sr <= {sop_sr[LAT-2:0], din_sop};
      eop_sr <= {eop_sr[LAT-2:0], din_eop};
    end
  end

  sobel_line_buf #(
    .IMG_W (IMG_W),
    .COL_W (COL_W)
  ) u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .din_vld (din_vld),
    .col     (cur_col),
    .tap0    (tap0),
    .tap1    (tap1),
    .tap2    (tap2)
  );

  // Window shifts left only when stage 1 holds a valid pixel; column 2 is the
  // newest column, row 0 the oldest line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win[i][j] <= '0;
        end
      end
    end else if (vld_sr[0]) begin
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= tap2;
      win[1][2] <= tap1;
      win[2][2] <= tap0;
    end
  end

  always_comb begin
    gx_c = grad_t'(tap_sum(win[0][2], win[1][2], win[2][2]) -
                   tap_sum(win[0][0], win[1][0], win[2][0]));
    gy_c = grad_t'(tap_sum(win[2][0], win[2][1], win[2][2]) -
                   tap_sum(win[0][0], win[0][1], win[0][2]));
    mag  = abs_grad(gx_q) + abs_grad(gy_q);
  end

  // Border flag travels alongside the data so the mask lines up with its pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      border_d1 <= 1'b0;
      border_d2 <= 1'b0;
      border_d3 <= 1'b0;
      gx_q      <= '0;
      gy_q      <= '0;
      dout      <= 1'b0;
    end else begin
      border_d1 <= border_in;
      border_d2 <= border_d1;
      border_d3 <= border_d2;
      gx_q      <= gx_c;
      gy_q      <= gy_c;
      dout      <= (mag >= thr_q) && !border_d3;
    end
  end

  assign dout_vld = vld_sr[LAT-1];
  assign dout_sop = sop_sr[LAT-1];
  assign dout_eop = eop_sr[LAT-1];

endmodule

// File: tb/tb_sobel_edge.sv
// tb_sobel_edge: self-checking bench for sobel_edge on an 8x4 image.
// Directed frames (flat, vertical/horizontal steps, threshold edge, gapped
// valid, 1x1 frame, mid-frame reset) plus random frames, each compared to a
// plain-arithmetic Sobel model of the whole image.
module tb_sobel_edge;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int LAT = 4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  din;
  logic        din_vld;
  logic        din_sop;
  logic        din_eop;
  logic [10:0] thresh;
  logic        dout;
  logic        dout_vld;
  logic        dout_sop;
  logic        dout_eop;

  typedef struct {
    int dout;
    int sop;
    int eop;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   img [H][W];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  sobel_edge #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_vld  (din_vld),
    .din_sop  (din_sop),
    .din_eop  (din_eop),
    .thresh   (thresh),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_sop (dout_sop),
    .dout_eop (dout_eop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed == expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Reference: Sobel over the whole stored image, border forced to 0.
  function automatic int expDout(input int r, input int c, input int thr);
    int gx, gy, mag;
    if (r < 2 || c < 2) return 0;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c]) -
         (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c]) -
         (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (mag >= thr) ? 1 : 0;
  endfunction

  task automatic fillImage(input int mode);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (mode)
          0:       img[r][c] = 128;
          1:       img[r][c] = (c >= 4) ? 200 : 0;
          2:       img[r][c] = (r >= 2) ? 200 : 0;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
      end
    end
  endtask

  task automatic idleCycles(input int n, input bit wiggle_thr);
    repeat (n) begin
      @(posedge clk);
      #1;
      din_vld = 1'b0;
      din_sop = 1'b0;
      din_eop = 1'b0;
      din     = 8'($urandom);
      if (wiggle_thr) thresh = 11'($urandom);
    end
  endtask

  // Sends the first npix pixels of img; gap < 0 means random 0..2 idle clocks.
  task automatic applyStimulus(input int thr, input int gap, input bit change_thr, input int npix);
    int sent;
    int g;
    sent = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (sent < npix) begin
          g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
          if (sent > 0) idleCycles(g, change_thr);
          @(posedge clk);
          #1;
          din     = 8'(img[r][c]);
          din_vld = 1'b1;
          din_sop = (r == 0 && c == 0);
          din_eop = (r == H-1 && c == W-1);
          if (din_sop) thresh = 11'(thr);
          else if (change_thr) thresh = 11'($urandom);
          exp_q.push_back('{expDout(r, c, thr), int'(din_sop), int'(din_eop), cyc + LAT});
          sent++;
        end
      end
    end
    idleCycles(1, 1'b0);
  endtask

  task automatic pulseResetMidFrame();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      din     = 8'($urandom);
      din_vld = 1'b1;
      @(posedge clk);
      #1;
    end
    din_vld = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: match each output beat against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_dout", int'(dout), 0);
      checkOutput("rst_vld",  int'(dout_vld), 0);
      checkOutput("rst_sop",  int'(dout_sop), 0);
      checkOutput("rst_eop",  int'(dout_eop), 0);
    end else if (dout_vld) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_vld", int'(dout_vld), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("dout",    int'(dout),     e.dout);
        checkOutput("sop",     int'(dout_sop), e.sop);
        checkOutput("eop",     int'(dout_eop), e.eop);
        checkOutput("latency", cyc,            e.cyc);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      checkOutput("missing_vld", int'(dout_vld), 1);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    int waited;
    rst_n   = 1'b0;
    din     = '0;
    din_vld = 1'b0;
    din_sop = 1'b0;
    din_eop = 1'b0;
    thresh  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleCycles(2, 1'b0);

    $display("[TB] flat frame");
    fillImage(0);
    applyStimulus(1, 0, 1'b0, W*H);
    idleCycles(6, 1'b0);

    $display("[TB] vertical step");
    fillImage(1);
    applyStimulus(100, 0, 1'b0, W*H);
    idleCycles(6, 1'b0);

    $display("[TB] horizontal step");
    fillImage(2);
    applyStimulus(100, 0, 1'b0, W*H);
    idleCycles(6, 1'b0);

    $display("[TB] threshold edge with mid-frame thresh changes");
    fillImage(1);
    applyStimulus(800, 0, 1'b1, W*H);
    idleCycles(6, 1'b0);
    applyStimulus(801, 0, 1'b1, W*H);
    idleCycles(6, 1'b0);

    $display("[TB] gapped valid");
    applyStimulus(100, 2, 1'b0, W*H);
    idleCycles(6, 1'b0);

    $display("[TB] single-pixel frame");
    @(posedge clk);
    #1;
    din     = 8'd255;
    din_vld = 1'b1;
    din_sop = 1'b1;
    din_eop = 1'b1;
    thresh  = 11'd0;
    exp_q.push_back('{0, 1, 1, cyc + LAT});
    idleCycles(6, 1'b0);

    $display("[TB] reset mid-frame");
    applyStimulus(100, 0, 1'b0, 2*W + 3);
    pulseResetMidFrame();
    idleCycles(2, 1'b0);
    applyStimulus(100, 0, 1'b0, W*H);
    idleCycles(6, 1'b0);

    $display("[TB] random frames");
    for (int f = 0; f < 6; f++) begin
      fillImage(3);
      applyStimulus(int'($urandom_range(0, 1200)), -1, 1'b1, W*H);
      idleCycles(6, 1'b0);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    checkOutput("drain", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
